mem_stage_dmem_ctrl: RTL
========================

// Module: mem_stage_dmem_ctrl
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register. Turns MemRead/MemWrite + ALU address
//  into a req/ack transaction on the data-memory bus, stalls the upstream pipeline while the
//  access is outstanding, and presents load data to the MEM/WB register. Handles slow memory,
//  bus timeout and (optionally) misaligned-address detection.
// PARAMETERS
//  TIMEOUT_CYCLES  64  BUSY cycles without ack before abort; 0 = never time out
//  CNT_W           7   width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clock__i         in   1   single clock, all state on rising edge
//  reset_n__i       in   1   asynchronous, active-low reset
//  MemRead__i       in   1   from EX/MEM: load in MEM stage
//  MemWrite__i      in   1   from EX/MEM: store in MEM stage
//  ALUData__i       in   32  from EX/MEM: byte address
//  MemWriteData__i  in   32  from EX/MEM: store data
//  dmem_req__o      out  1   bus request, held until ack or abort
//  dmem_we__o       out  1   1 = write, 0 = read; valid with req
//  dmem_addr__o     out  32  word address, [1:0] always 2'b00
//  dmem_wdata__o    out  32  store data; valid with req & we
//  dmem_ack__i      in   1   one-cycle completion strobe from memory
//  dmem_rdata__i    in   32  read data, valid with ack when we=0
//  Stall__o         out  1   hold PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB
//  MemReadData__o   out  32  captured load data to MEM/WB
//  BusErr__o        out  1   1-cycle pulse in DONE when access timed out
//  AddrErr__o       out  1   1-cycle pulse in DONE on misaligned access (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async): state IDLE; req/we/BusErr/AddrErr/Stall 0; addr/wdata/MemReadData/count 0.
//    Reset mid-transaction drops dmem_req__o immediately; no completion reported.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: if MemRead|MemWrite: Stall__o=1 (comb); next edge latch addr/wdata/we, req=1, count=0,
//      go BUSY. MemWrite wins if both asserted (we=1). No access: Stall__o=0, stay IDLE.
//    BUSY: Stall__o=1, req held, addr/wdata/we stable. Ack sampled at edge: read -> latch
//      rdata into MemReadData__o; req=0; go DONE. No ack: count++; count==TIMEOUT_CYCLES-1
//      (TIMEOUT_CYCLES!=0) -> req=0, MemReadData__o=0, BusErr__o=1 in DONE, go DONE.
//    DONE: Stall__o=0 (EX/MEM and MEM/WB advance this edge); never launches; next state IDLE.
//  - Latency: ack on first BUSY cycle gives 2 stall cycles + DONE (3 cycles per memory op).
//  - Stores leave MemReadData__o unchanged. Back-to-back memory ops: one non-stall cycle
//    (DONE) between accesses.
//  - Ack in IDLE or DONE: ignored, no state change. Ack and timeout same edge: ack wins.
//  - Stall__o is combinational from state and MemRead/MemWrite; all other outputs registered.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: in IDLE, access with ALUData__i[1:0]!=0 issues no bus request;
//    next edge go directly DONE with AddrErr__o=1 (1 stall cycle); MemReadData__o unchanged.
//  Undefined: no check; dmem_addr__o = {ALUData__i[31:2],2'b00}; AddrErr__o tied 0.
// STRUCTURE
//  Shared package mips_pkg: typedef enum logic [1:0] {DMEM_IDLE,DMEM_BUSY,DMEM_DONE} dmem_state_t;
//  localparam DMEM_WORD_BYTES=4. Single module, no sub-modules; timeout counter inline.
// TESTING
//  1 Load, ack 1st BUSY cycle, addr 0x100, rdata 0xCAFEF00D -> req 1 cycle, Stall 2 cycles,
//    MemReadData 0xCAFEF00D in DONE, we=0.
//  2 Store addr 0x204 data 0x12345678, ack after 5 BUSY cycles -> we=1, addr/wdata stable all
//    5 cycles, Stall 6 cycles, MemReadData unchanged.
//  3 Load, no ack, TIMEOUT_CYCLES=4 -> req drops after 4 BUSY cycles, BusErr pulse 1 cycle,
//    MemReadData 0; TIMEOUT_CYCLES=0 -> stall persists 200+ cycles.
//  4 MemRead=MemWrite=1 addr 0x8 -> write issued; stray ack in IDLE -> no effect.
//  5 reset_n low during BUSY -> req 0 same cycle without clock; after release IDLE, Stall 0.
//  6 Addr 0x103 load: with MEM_ALIGN_CHECK_EN -> no req, AddrErr pulse, 1 stall cycle;
//    without -> dmem_addr 0x100, normal load.

Source files
------------

// File: rtl/mem_stage_dmem_ctrl_pkg.sv
// mem_stage_dmem_ctrl_pkg: shared types and constants for the MEM-stage
// data-memory controller.
package mem_stage_dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_BUSY,
    DMEM_DONE
  } dmem_state_t;

  localparam int DMEM_WORD_BYTES = 4;

endpackage

// File: rtl/mem_stage_dmem_ctrl_if.sv
// mem_stage_dmem_ctrl_if: req/ack data-memory bus between the MEM-stage
// controller (master) and the data memory (slave).
interface mem_stage_dmem_ctrl_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );

endinterface

// File: rtl/mem_stage_dmem_ctrl.sv
// mem_stage_dmem_ctrl: MEM-stage consumer of the EX/MEM register. Turns a
// load/store into one req/ack bus transaction, stalls the pipeline while it
// is outstanding, aborts after TIMEOUT_CYCLES silent BUSY cycles (0 = never)
// and hands load data to MEM/WB.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned accesses
// with a one-cycle AddrErr__o pulse instead of issuing a bus request.
module mem_stage_dmem_ctrl
  import mem_stage_dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic                         clock__i,
  input  logic                         reset_n__i,
  input  logic                         MemRead__i,
  input  logic                         MemWrite__i,
  input  logic [31:0]                  ALUData__i,
  input  logic [31:0]                  MemWriteData__i,
  mem_stage_dmem_ctrl_if.master        dmem,
  output logic                         Stall__o,
  output logic [31:0]                  MemReadData__o,
  output logic                         BusErr__o,
  output logic                         AddrErr__o
);

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  localparam bit               TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] LAST_COUNT  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      OFFSET_MASK = 32'(DMEM_WORD_BYTES - 1);

  dmem_state_t      state;
  dmem_state_t      next_state;
  logic [CNT_W-1:0] count;
  logic             access;
  logic             misaligned;
  logic             timeout_hit;

  assign access      = MemRead__i | MemWrite__i;
  assign misaligned  = ALIGN_CHECK && ((ALUData__i & OFFSET_MASK) != 32'd0);
  assign timeout_hit = TIMEOUT_EN && (count == LAST_COUNT);

  // State register; reset abandons any outstanding access without completion.
  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) state <= DMEM_IDLE;
    else             state <= next_state;
  end

  // Next state: launch from IDLE, leave BUSY on ack or timeout, DONE lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      DMEM_IDLE: if (access) next_state = misaligned ? DMEM_DONE : DMEM_BUSY;
      DMEM_BUSY: if (dmem.dmem_ack || timeout_hit) next_state = DMEM_DONE;
      DMEM_DONE: next_state = DMEM_IDLE;
      default:   next_state = DMEM_IDLE;
    endcase
  end

  // Stall is the only combinational output: held from access request until DONE.
  always_comb begin
    Stall__o = 1'b0;
    case (state)
      DMEM_IDLE: Stall__o = access;
      DMEM_BUSY: Stall__o = 1'b1;
      default:   Stall__o = 1'b0;
    endcase
  end

  // Bus request, captured access fields, load data, error pulses and timeout counter.
  always_ff @(posedge clock__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= 32'd0;
      dmem.dmem_wdata <= 32'd0;
      MemReadData__o  <= 32'd0;
      BusErr__o       <= 1'b0;
      AddrErr__o      <= 1'b0;
      count           <= '0;
    end else begin
      BusErr__o  <= 1'b0;
      AddrErr__o <= 1'b0;
      case (state)
        DMEM_IDLE: begin
          if (access) begin
            if (misaligned) begin
              AddrErr__o <= 1'b1;
            end else begin
              dmem.dmem_req   <= 1'b1;
              dmem.dmem_we    <= MemWrite__i;
              dmem.dmem_addr  <= ALUData__i & ~OFFSET_MASK;
              dmem.dmem_wdata <= MemWriteData__i;
              count           <= '0;
            end
          end
        end
        DMEM_BUSY: begin
          if (dmem.dmem_ack) begin
            dmem.dmem_req <= 1'b0;
            if (!dmem.dmem_we) MemReadData__o <= dmem.dmem_rdata;
          end else if (timeout_hit) begin
            dmem.dmem_req  <= 1'b0;
            MemReadData__o <= 32'd0;
            BusErr__o      <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
